// File: rtl/muldiv_sequencial.sv
// Sequential unsigned multiply/divide unit with architectural HI/LO registers.
// Latency: multiply and divide take N cycles after the start edge; divide by zero takes 1; moves take effect on the start edge.
// Backpressure: ocupado is high while an operation runs and any start request during that time is dropped.
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   inicio, operacao    - start request and opcode (00 mul, 01 div, 10 RS->HI, 11 RS->LO)
//   RS, RT              - operands (multiplicand/dividend, multiplier/divisor)
//   ocupado, pronto     - busy flag, one-cycle completion pulse
//   divZero             - last divide had a zero divisor
//   saidaHI, saidaLO    - architectural HI and LO registers
module muldiv_sequencial #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inicio,
  input  logic [1:0]   operacao,
  input  logic [N-1:0] RS,
  input  logic [N-1:0] RT,
  output logic         ocupado,
  output logic         pronto,
  output logic         divZero,
  output logic [N-1:0] saidaHI,
  output logic [N-1:0] saidaLO
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  // opnd holds the multiplicand (MULT) or the divisor (DIV).
  // acc_lo starts as the multiplier / dividend and is shifted out one bit
  // per step while the product / quotient bits are shifted in behind it.
  logic [N-1:0]   opnd;
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole pair right.
  logic [N:0]     mul_sum;
  logic [N-1:0]   mul_hi;
  logic [N-1:0]   mul_lo;

  // Restoring-division step: shift the partial remainder left by one
  // dividend bit and try to subtract the divisor. The remainder is always
  // below the divisor, so the shifted value fits N+1 bits and bit N of the
  // difference is a reliable "went negative" flag.
  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic           div_ok;
  logic [N-1:0]   div_hi;
  logic [N-1:0]   div_lo;

  logic           last;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(N+1){1'b0}});
  assign mul_hi    = mul_sum[N:1];
  assign mul_lo    = {mul_sum[0], acc_lo[N-1:1]};

  assign div_shift = {acc_hi, acc_lo[N-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[N];
  assign div_hi    = div_ok ? div_diff[N-1:0] : div_shift[N-1:0];
  assign div_lo    = {acc_lo[N-2:0], div_ok};

  assign last      = (cnt == CW'(N - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= OCIOSO;
      cnt     <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      divZero <= 1'b0;
      saidaHI <= '0;
      saidaLO <= '0;
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: begin
          if (inicio) begin
            case (operacao)
              2'b00: begin
                opnd    <= RS;
                acc_lo  <= RT;
                acc_hi  <= '0;
                cnt     <= '0;
                state   <= MULT;
                ocupado <= 1'b1;
              end
              2'b01: begin
                opnd    <= RT;
                acc_lo  <= RS;
                acc_hi  <= '0;
                cnt     <= '0;
                state   <= DIV;
                ocupado <= 1'b1;
              end
              2'b10:   saidaHI <= RS;
              default: saidaLO <= RS;
            endcase
          end
        end

        MULT: begin
          acc_hi <= mul_hi;
          acc_lo <= mul_lo;
          cnt    <= cnt + 1'b1;
          if (last) begin
            saidaHI <= mul_hi;
            saidaLO <= mul_lo;
            state   <= OCIOSO;
            ocupado <= 1'b0;
            pronto  <= 1'b1;
          end
        end

        DIV: begin
          if (opnd == '0) begin
            // Zero divisor: acc_lo still holds the untouched dividend.
            saidaHI <= acc_lo;
            saidaLO <= '1;
            divZero <= 1'b1;
            state   <= OCIOSO;
            ocupado <= 1'b0;
            pronto  <= 1'b1;
          end else begin
            acc_hi <= div_hi;
            acc_lo <= div_lo;
            cnt    <= cnt + 1'b1;
            if (last) begin
              saidaHI <= div_hi;
              saidaLO <= div_lo;
              divZero <= 1'b0;
              state   <= OCIOSO;
              ocupado <= 1'b0;
              pronto  <= 1'b1;
            end
          end
        end

        default: begin
          state   <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencial.sv
// Scoreboard bench for muldiv_sequencial: a driver issues operations and pushes
// the expected HI/LO/divZero/busy-length, a monitor pops on every pronto pulse.
module tb_muldiv_sequencial;

  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         inicio;
  logic [1:0]   operacao;
  logic [N-1:0] RS;
  logic [N-1:0] RT;
  logic         ocupado;
  logic         pronto;
  logic         divZero;
  logic [N-1:0] saidaHI;
  logic [N-1:0] saidaLO;

  muldiv_sequencial #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .inicio   (inicio),
    .operacao (operacao),
    .RS       (RS),
    .RT       (RT),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .divZero  (divZero),
    .saidaHI  (saidaHI),
    .saidaLO  (saidaLO)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;
    int           busy;
  } exp_t;

  exp_t         sb[$];
  int           vectors    = 0;
  int           miscompares = 0;

  // Architectural state as the reference model sees it.
  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per pronto pulse.
  int   busy_cnt = 0;
  logic prev_pronto = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      busy_cnt    = 0;
      prev_pronto = 1'b0;
    end else begin
      if (ocupado) busy_cnt++;
      if (pronto) begin
        chk("pronto_single_cycle", {63'd0, prev_pronto}, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_pronto", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result_hi", {32'd0, saidaHI}, {32'd0, e.hi});
          chk("result_lo", {32'd0, saidaLO}, {32'd0, e.lo});
          chk("result_divzero", {63'd0, divZero}, {63'd0, e.dz});
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
        end
        busy_cnt = 0;
      end
      prev_pronto = pronto;
    end
  end

  // Reference model: plain wide arithmetic, no bit-level iteration.
  task automatic model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t        e;
    logic [63:0] p;
    case (op)
      2'b00: begin
        p    = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        e.busy = N;
      end
      2'b01: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = '1;
          m_dz = 1'b1;
          e.busy = 1;
        end else begin
          m_hi = a % b;
          m_lo = a / b;
          m_dz = 1'b0;
          e.busy = N;
        end
      end
      2'b10:   m_hi = a;
      default: m_lo = a;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    e.dz = m_dz;
    if (op[1] == 1'b0) sb.push_back(e);
  endtask

  // Called and returns at a falling edge.
  task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int t;
    t = 0;
    while (ocupado && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 64'd1, 64'd0);
    inicio   = 1'b1;
    operacao = op;
    RS       = a;
    RT       = b;
    model(op, a, b);
    @(posedge clock);
    #1;
    if (op[1]) begin
      chk("move_hi", {32'd0, saidaHI}, {32'd0, m_hi});
      chk("move_lo", {32'd0, saidaLO}, {32'd0, m_lo});
      chk("move_no_busy", {63'd0, ocupado}, 64'd0);
    end else begin
      chk("start_busy", {63'd0, ocupado}, 64'd1);
    end
    @(negedge clock);
    inicio   = 1'b0;
    // Scramble inputs so a design that reads them after the start edge shows it.
    RS       = $urandom;
    RT       = $urandom;
    operacao = 2'($urandom);
    if (op[1]) chk("move_no_pronto", {63'd0, pronto}, 64'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || ocupado) && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (t >= 500) chk("drain_timeout", 64'd1, 64'd0);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset    = 1'b1;
    inicio   = 1'b0;
    operacao = 2'b00;
    RS       = '0;
    RT       = '0;
    #1;
    chk("reset_hi", {32'd0, saidaHI}, 64'd0);
    chk("reset_lo", {32'd0, saidaLO}, 64'd0);
    chk("reset_flags", {61'd0, ocupado, pronto, divZero}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Directed vectors.
    issue(2'b00, 32'd7, 32'd6);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b01, 32'd100, 32'd7);
    issue(2'b01, 32'd5, 32'd0);
    issue(2'b10, 32'hAAAA_5555, 32'd0);
    issue(2'b11, 32'h1234_5678, 32'd0);
    issue(2'b01, 32'hFFFF_FFFF, 32'd1);
    issue(2'b01, 32'd3, 32'd10);
    drain();

    // Start request while busy must be dropped.
    issue(2'b00, 32'd3, 32'd4);
    repeat (3) @(negedge clock);
    inicio   = 1'b1;
    operacao = 2'b01;
    RS       = 32'd9;
    RT       = 32'd2;
    @(negedge clock);
    inicio   = 1'b0;
    drain();
    chk("ignored_start_hi", {32'd0, saidaHI}, 64'd0);
    chk("ignored_start_lo", {32'd0, saidaLO}, 64'd12);

    // Asynchronous reset in the middle of a divide.
    issue(2'b01, 32'd1000, 32'd3);
    repeat (8) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("midop_reset_hi", {32'd0, saidaHI}, 64'd0);
    chk("midop_reset_lo", {32'd0, saidaLO}, 64'd0);
    chk("midop_reset_flags", {61'd0, ocupado, pronto, divZero}, 64'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    issue(2'b00, 32'd2, 32'd3);
    drain();

    // Randomized operations, back to back (new start lands on the pronto cycle).
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = N'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = N'($urandom_range(0, 255));
      issue(op, a, b);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
